ternary_fc_engine: RTL and testbench



---
 rtl/ternary_pkg.sv | 16 +
 rtl/ternary_fc_engine_if.sv | 17 +
 rtl/ternary_mac_lane.sv | 34 +++
 rtl/ternary_fc_engine.sv | 89 ++++++++
 tb/tb_ternary_fc_engine.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ternary_pkg.sv
// ternary_pkg: ternary encodings, FSM states and arithmetic helpers shared by the FC engine
package ternary_pkg;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_ZERO = 2'b00;
  typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_OUT} state_t;
  // Bit 0 clear means zero, so 2'b10 decodes to zero alongside TERN_ZERO
  function automatic logic signed [1:0] tern_mul(input logic [1:0] a, input logic [1:0] b);
    return (!a[0] || !b[0]) ? 2'sd0 : (a == b) ? 2'sd1 : -2'sd1;
  endfunction
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return v > hi ? hi : v < -hi - 32'sd1 ? -hi - 32'sd1 : v;
  endfunction
endpackage

// File: rtl/ternary_fc_engine_if.sv
// ternary_fc_engine_if: activation/weight input stream and classifier result handshake
interface ternary_fc_engine_if #(
  parameter int N_OUT = 10,
  parameter int OUT_W = 8,
  parameter int CLS_W = N_OUT > 1 ? $clog2(N_OUT) : 1
);
  logic [1:0]             i_data;
  logic [2*N_OUT-1:0]     i_weight;
  logic                   i_valid;
  logic                   i_ready;
  logic [OUT_W*N_OUT-1:0] o_data;
  logic [CLS_W-1:0]       o_class;
  logic                   o_valid;
  logic                   o_ready;
  modport master (output i_data, i_weight, i_valid, o_ready, input i_ready, o_data, o_class, o_valid);
  modport slave  (input i_data, i_weight, i_valid, o_ready, output i_ready, o_data, o_class, o_valid);
endinterface

// File: rtl/ternary_mac_lane.sv
// ternary_mac_lane: registered ternary product feeding an accumulator that restarts on a frame's first beat
module ternary_mac_lane
  import ternary_pkg::*;
#(
  parameter int ACC_W = 13
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    beat_i,
  input  logic                    first_i,
  input  logic [1:0]              data_i,
  input  logic [1:0]              weight_i,
  output logic signed [ACC_W-1:0] acc_o
);
  logic signed [1:0]       prod_q;
  logic                    pv_q, pf_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  // The first beat overwrites, so frames run back to back without a clear cycle
  always_comb acc_d = !pv_q ? acc_q : pf_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      pf_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= tern_mul(data_i, weight_i);
      pv_q   <= beat_i;
      pf_q   <= beat_i && first_i;
      acc_q  <= acc_d;
    end
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/ternary_fc_engine.sv
// ternary_fc_engine: N_OUT-lane ternary fully-connected layer with shift/saturate and argmax class output
module ternary_fc_engine
  import ternary_pkg::*;
#(
  parameter int IN_LEN = 2304,
  parameter int N_OUT  = 10,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 1
) (
  input  logic clk,
  input  logic resetn,
  ternary_fc_engine_if.slave bus
);
  localparam int ACC_W = $clog2(IN_LEN + 1) + 1;
  localparam int CNT_W = $clog2(IN_LEN);
  localparam int CLS_W = N_OUT > 1 ? $clog2(N_OUT) : 1;
  state_t                 st_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   dr_q;
  logic                   ov_q;
  logic [OUT_W*N_OUT-1:0] od_q, sat_d;
  logic [CLS_W-1:0]       oc_q, cls_d;
  logic signed [ACC_W-1:0] acc [N_OUT];
  logic signed [OUT_W-1:0] sat_v [N_OUT];
  logic signed [OUT_W-1:0] best;
  logic beat, last;
  assign beat = st_q == ST_ACC && bus.i_valid;
  assign last = cnt_q == CNT_W'(IN_LEN - 1);
  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    ternary_mac_lane #(.ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .resetn  (resetn),
      .beat_i  (beat),
      .first_i (cnt_q == '0),
      .data_i  (bus.i_data),
      .weight_i(bus.i_weight[2*g +: 2]),
      .acc_o   (acc[g])
    );
    assign sat_v[g] = OUT_W'(sat_signed(32'(acc[g]) >>> SHIFT, OUT_W));
    assign sat_d[OUT_W*g +: OUT_W] = sat_v[g];
  end
  // Strict compare keeps the lowest index on ties
  always_comb begin
    best  = sat_v[0];
    cls_d = '0;
    for (int n = 1; n < N_OUT; n++) begin
      if (sat_v[n] > best) begin
        best  = sat_v[n];
        cls_d = CLS_W'(n);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q  <= ST_ACC;
      cnt_q <= '0;
      dr_q  <= 1'b0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      oc_q  <= '0;
    end else begin
      case (st_q)
        ST_ACC: if (beat) begin
          cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
          dr_q  <= 1'b0;
          if (last) st_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          dr_q <= 1'b1;
          if (dr_q) begin
            st_q <= ST_OUT;
            ov_q <= 1'b1;
            od_q <= sat_d;
            oc_q <= cls_d;
          end
        end
        ST_OUT: if (bus.o_ready) begin
          st_q <= ST_ACC;
          ov_q <= 1'b0;
        end
        default: st_q <= ST_ACC;
      endcase
    end
  end
  assign bus.i_ready = st_q == ST_ACC && resetn;
  assign bus.o_valid = ov_q;
  assign bus.o_data  = od_q;
  assign bus.o_class = oc_q;
endmodule

// File: tb/tb_ternary_fc_engine.sv
// tb_ternary_fc_engine: directed frames on the full-size engine plus reference-model frames on small SHIFT 0..3 engines
module tb_ternary_fc_engine;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  ternary_fc_engine_if #(.N_OUT(10), .OUT_W(8)) bus ();
  ternary_fc_engine #(.IN_LEN(2304), .N_OUT(10), .OUT_W(8), .SHIFT(1)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  logic [1:0]  sd;
  logic [5:0]  sw;
  logic        s_iv, s_or;
  logic [11:0] s_od [4];
  logic [1:0]  s_oc [4];
  logic        s_ov [4];
  logic        s_rdy [4];
  for (genvar g = 0; g < 4; g++) begin : g_s
    ternary_fc_engine_if #(.N_OUT(3), .OUT_W(4)) sif ();
    ternary_fc_engine #(.IN_LEN(20), .N_OUT(3), .OUT_W(4), .SHIFT(g)) sdut (
      .clk(clk), .resetn(resetn), .bus(sif)
    );
    assign sif.i_data   = sd;
    assign sif.i_weight = sw;
    assign sif.i_valid  = s_iv;
    assign sif.o_ready  = s_or;
    assign s_od[g]  = sif.o_data;
    assign s_oc[g]  = sif.o_class;
    assign s_ov[g]  = sif.o_valid;
    assign s_rdy[g] = sif.i_ready;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tv(input logic [1:0] c);
    return c == 2'b01 ? 1 : c == 2'b11 ? -1 : 0;
  endfunction

  function automatic int satm(input int v, input int w);
    int hi;
    hi = (1 << (w - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction

  function automatic int lane(input int n);
    logic [7:0] v;
    v = bus.o_data[8*n +: 8];
    return int'($signed(v));
  endfunction

  task automatic gen(input int mode, input int b, output logic [1:0] d, output logic [19:0] w);
    w = '0;
    d = 2'b01;
    case (mode)
      0: w = {10{2'b01}};
      1: w[7:6] = 2'b11;
      2: w[15:14] = b < 300 ? 2'b01 : 2'b10;
      3: w[15:14] = b < 200 ? 2'b01 : 2'b10;
      default: begin
        d = b % 3 == 0 ? 2'b10 : b % 3 == 1 ? 2'b00 : 2'b01;
        for (int n = 0; n < 10; n++)
          w[2*n +: 2] = n < 4 ? (n % 2 == 1 ? 2'b10 : 2'b00) : n == 4 ? 2'b01 : 2'b11;
      end
    endcase
  endtask

  task automatic main_frame(input int mode, input int stall, input int abort_at,
                            input int hl, input int hv, input int hc);
    int acc [10];
    int e, be, bc, k;
    logic [1:0]  d;
    logic [19:0] w;
    logic [79:0] snap;
    logic [3:0]  sc;
    for (int n = 0; n < 10; n++) acc[n] = 0;
    for (int b = 0; b < 2304; b++) begin
      if (abort_at > 0 && b == abort_at) return;
      gen(mode, b, d, w);
      bus.i_data = d;
      bus.i_weight = w;
      bus.i_valid = 1'b1;
      k = 0;
      while (!bus.i_ready && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      if (!bus.i_ready) begin
        check("ready_timeout", 0, 1);
        return;
      end
      for (int n = 0; n < 10; n++) acc[n] += tv(d) * tv(w[2*n +: 2]);
      @(posedge clk); #1;
    end
    check("ready_drop_t1", bus.i_ready, 0);
    check("ov_t1", bus.o_valid, 0);
    @(posedge clk); #1;
    check("ov_t2", bus.o_valid, 0);
    @(posedge clk); #1;
    check("ov_t3", bus.o_valid, 1);
    be = -1000;
    bc = 0;
    for (int n = 0; n < 10; n++) begin
      e = satm(acc[n] >>> 1, 8);
      check($sformatf("m%0d_lane%0d", mode, n), lane(n), e);
      if (e > be) begin
        be = e;
        bc = n;
      end
    end
    check($sformatf("m%0d_class", mode), bus.o_class, bc);
    if (hl >= 0) check($sformatf("m%0d_hand_lane%0d", mode, hl), lane(hl), hv);
    if (hc >= 0) check($sformatf("m%0d_hand_class", mode), bus.o_class, hc);
    snap = bus.o_data;
    sc = bus.o_class;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_data", bus.o_data == snap, 1);
      check("stall_class", bus.o_class, sc);
      check("stall_ov", bus.o_valid, 1);
      check("stall_ready", bus.i_ready, 0);
    end
    bus.o_ready = 1'b1;
    @(posedge clk); #1;
    bus.o_ready = 1'b0;
    check("ov_drop", bus.o_valid, 0);
    check("ready_back", bus.i_ready, 1);
  endtask

  task automatic small_frame(input int mode);
    int acc [3];
    int e, be, bc, k;
    logic [1:0] d;
    logic [5:0] w;
    logic [3:0] v;
    for (int n = 0; n < 3; n++) acc[n] = 0;
    for (int b = 0; b < 20; b++) begin
      d = mode == 0 ? 2'($urandom_range(0, 3)) : 2'b01;
      w = mode == 0 ? 6'($urandom_range(0, 63)) : mode == 1 ? 6'b010101 : 6'b111111;
      sd = d;
      sw = w;
      s_iv = 1'b1;
      k = 0;
      while (!s_rdy[0] && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      for (int n = 0; n < 3; n++) acc[n] += tv(d) * tv(w[2*n +: 2]);
      @(posedge clk); #1;
    end
    s_iv = 1'b0;
    k = 0;
    while (!s_ov[0] && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("small_ov", s_ov[0], 1);
    for (int s = 0; s < 4; s++) begin
      be = -1000;
      bc = 0;
      for (int n = 0; n < 3; n++) begin
        e = satm(acc[n] >>> s, 4);
        v = s_od[s][4*n +: 4];
        check($sformatf("small_sh%0d_lane%0d", s, n), int'($signed(v)), e);
        if (e > be) begin
          be = e;
          bc = n;
        end
      end
      check($sformatf("small_sh%0d_class", s), s_oc[s], bc);
    end
    s_or = 1'b1;
    @(posedge clk); #1;
    s_or = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_ov", bus.o_valid, 0);
    check("rst_data", bus.o_data == '0, 1);
    check("rst_class", bus.o_class, 0);
    check("rst_ready", bus.i_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_data = 2'b00;
    bus.i_weight = '0;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    sd = 2'b00;
    sw = '0;
    s_iv = 1'b0;
    s_or = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    check("rst_small_ready", s_rdy[0], 0);
    resetn = 1'b1;
    #1;
    check("ready_after_release", bus.i_ready, 1);
    main_frame(0, 20, 0, 0, 127, 0);
    main_frame(1, 0, 0, 3, -128, 0);
    main_frame(2, 0, 0, 7, 127, -1);
    main_frame(3, 0, 0, 7, 100, 7);
    main_frame(4, 0, 0, 4, 127, 4);
    main_frame(0, 0, 1000, -1, 0, -1);
    resetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_values();
    resetn = 1'b1;
    #1;
    check("ready_after_midframe_rst", bus.i_ready, 1);
    main_frame(1, 0, 0, 3, -128, 0);
    bus.i_valid = 1'b0;
    small_frame(1);
    small_frame(2);
    for (int i = 0; i < 6; i++) small_frame(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
